de_packetizer: RTL and testbench
================================

Name: de_packetizer

Overview:
- Converts 48-bit network flits arriving on `flitoutde` into a stream of 16-bit words on `data_out`.
- Flags the last word of each packet on `packet_end`.
- Sits at the NoC egress, between the router output port and the consumer core.
- Has no input valid strobe: a new flit is detected by its control word and by a change in value.

Parameters:
- FLIT_W, 48: input flit width; fixed as 3 × WORD_W.
- WORD_W, 16: output word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flitoutde  input  48  incoming flit (format below).
- data_out  output  16  registered payload word.
- packet_end  output  1  registered; high for exactly the cycle `data_out` carries the final word of a packet.

Behaviour:
- Flit format:
  - [47:32] payload word 0; [31:16] payload word 1; [15:0] control word.
  - Control bit 15 = VALID, bit 14 = TAIL (last flit of packet); bits 13:0 are ignored.
  - 16'hFFFF is therefore a valid tail flit.
- Reset: clk edge with reset=1 forces state=IDLE, data_out=16'h0000, packet_end=0, last_flit=48'h0, have_last=0. Reset overrides everything, including mid-serialization; the partially sent flit is dropped.
- Acceptance condition at a clock edge:
  - flitoutde[15]==1, AND
  - (have_last==0 OR flitoutde != last_flit), AND
  - state is IDLE or SEND1.
- On acceptance: capture the flit into the holding register, set last_flit=flitoutde, have_last=1.
- A flit with VALID=0 is never accepted. An X/Z control word counts as VALID=0.
- A held (unchanged) flit is accepted only once. The identical flit value is re-accepted only after a different valid flit has been accepted in between.
- State machine:
  - IDLE: on acceptance, data_out<=flit[47:32], packet_end<=0, go to SEND1. Otherwise data_out<=0, packet_end<=0.
  - SEND1: data_out<=held[31:16], packet_end<=held TAIL bit. Next state: if acceptance is true this same edge, capture the new flit and go to SEND0_PEND; else go to IDLE.
  - SEND0_PEND: data_out<=held_new[47:32], packet_end<=0, go to SEND1. This back-to-back path produces no bubble.
- Latency: word 0 appears on data_out at the first edge at which the flit is accepted. Word 1 appears one cycle later.
- Throughput: one flit per two cycles, sustained.
- Non-tail flit (VALID=1, TAIL=0): both words are emitted with packet_end=0, and the packet continues with the next flit. There is no length limit.
- Flit changing while in SEND1/SEND0_PEND: the held copy is emitted; the input is sampled only at acceptance points.
- Flit changing to a new valid value and back to the original: both are accepted, each in turn.

Test Plan:
- Reset held for 1 edge with flitoutde=X -> data_out=16'h0000, packet_end=0; no acceptance while the input is X.
- After reset, flitoutde=48'h1234_ABCD_FFFF from t=20ns (edge at 25ns):
  - edge 25 -> data_out=16'h1234, packet_end=0.
  - edge 35 -> data_out=16'hABCD, packet_end=1.
- Change to 48'h3232_6767_FFFF before edge 45, then hold for 1000ns:
  - edge 45 -> 16'h3232/0; edge 55 -> 16'h6767/1.
  - All later edges -> 16'h0000/0 (no re-acceptance of the held flit).
- Non-tail flit 48'hAAAA_BBBB_8000 followed by 48'hCCCC_DDDD_C000 applied at consecutive acceptance points -> words AAAA, BBBB, CCCC, DDDD on four consecutive edges; packet_end=1 only with DDDD.
- Invalid flit 48'h1111_2222_7FFF -> never accepted; outputs stay 0.
- Assert reset on the edge where data_out=16'h1234 would advance to ABCD -> outputs 0 at that edge. After reset deasserts, the same held flit is re-accepted (have_last cleared) and 1234, ABCD are emitted again.

Source files
------------

// File: rtl/de_packetizer.sv
// NoC egress de-packetizer: serialises 48-bit flits into 16-bit words, word 0 first,
// and marks the final word of a tail flit on packet_end.
`timescale 1ns/1ps

module de_packetizer #(
    parameter int WORD_W = 16,
    parameter int FLIT_W = 3 * WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] flitoutde,
    output logic [WORD_W-1:0] data_out,
    output logic              packet_end
);

    localparam int HELD_W = 2 * WORD_W + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND1      = 2'd1,
        SEND0_PEND = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    // Held copy keeps only what is still needed: both payload words plus the TAIL bit.
    logic [HELD_W-1:0]   r_held, w_held_next;
    logic [FLIT_W-1:0]   r_last_flit, w_last_flit_next;
    logic                r_have_last, w_have_last_next;
    logic [WORD_W-1:0]   r_data_out, w_data_out_next;
    logic                r_packet_end, w_packet_end_next;

    logic                w_valid;
    logic                w_is_new;
    logic                w_ready;
    logic                w_accept;

    // No input strobe: a flit counts only when VALID is set and it differs from the last one taken.
    assign w_valid  = (flitoutde[WORD_W-1] == 1'b1);
    assign w_is_new = !r_have_last || (flitoutde != r_last_flit);
    assign w_ready  = (r_state == IDLE) || (r_state == SEND1);
    assign w_accept = w_valid && w_is_new && w_ready;

    always_comb begin
        w_state_next      = r_state;
        w_held_next       = r_held;
        w_last_flit_next  = r_last_flit;
        w_have_last_next  = r_have_last;
        w_data_out_next   = '0;
        w_packet_end_next = 1'b0;

        if (w_accept) begin
            w_held_next      = {flitoutde[FLIT_W-1:WORD_W], flitoutde[WORD_W-2]};
            w_last_flit_next = flitoutde;
            w_have_last_next = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_data_out_next = flitoutde[FLIT_W-1:2*WORD_W];
                    w_state_next    = SEND1;
                end
            end
            SEND1: begin
                w_data_out_next   = r_held[WORD_W:1];
                w_packet_end_next = r_held[0];
                // Accepting here chains straight into the next flit without a bubble.
                w_state_next      = w_accept ? SEND0_PEND : IDLE;
            end
            SEND0_PEND: begin
                w_data_out_next = r_held[HELD_W-1:WORD_W+1];
                w_state_next    = SEND1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_held       <= '0;
            r_last_flit  <= '0;
            r_have_last  <= 1'b0;
            r_data_out   <= '0;
            r_packet_end <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_held       <= w_held_next;
            r_last_flit  <= w_last_flit_next;
            r_have_last  <= w_have_last_next;
            r_data_out   <= w_data_out_next;
            r_packet_end <= w_packet_end_next;
        end
    end

    assign data_out   = r_data_out;
    assign packet_end = r_packet_end;

endmodule

// File: tb/tb_de_packetizer.sv
// Bench for de_packetizer: directed scenarios then random flits, all checked against a
// queue-based model of pending output words.
`timescale 1ns/1ps

module tb_de_packetizer;

    logic        clk;
    logic        reset;
    logic [47:0] flitoutde;
    logic [15:0] data_out;
    logic        packet_end;

    int n_checks;
    int n_fail;

    // Model state: words waiting to be emitted ({packet_end, word}) and last accepted flit.
    logic [16:0] m_q[$];
    logic [47:0] m_last;
    logic        m_have;
    logic [15:0] exp_data;
    logic        exp_end;

    de_packetizer dut (
        .clk       (clk),
        .reset     (reset),
        .flitoutde (flitoutde),
        .data_out  (data_out),
        .packet_end(packet_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge of the reference behaviour. A flit may be taken only while at most
    // one word is still pending; its two words join the queue, then the front word is emitted.
    task automatic model_edge(input logic [47:0] f, input logic rst);
        logic [16:0] e;
        if (rst) begin
            m_q.delete();
            m_have   = 1'b0;
            m_last   = 48'h0;
            exp_data = 16'h0000;
            exp_end  = 1'b0;
        end else begin
            if ((f[15] === 1'b1) && (!m_have || (f !== m_last)) && (m_q.size() <= 1)) begin
                m_q.push_back({1'b0, f[47:32]});
                m_q.push_back({f[14], f[31:16]});
                m_last = f;
                m_have = 1'b1;
            end
            if (m_q.size() > 0) begin
                e        = m_q.pop_front();
                exp_data = e[15:0];
                exp_end  = e[16];
            end else begin
                exp_data = 16'h0000;
                exp_end  = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [47:0] f, input logic rst, input string tag);
        flitoutde = f;
        reset     = rst;
        @(posedge clk);
        model_edge(f, rst);
        #1;
        n_checks++;
        assert (data_out === exp_data) else begin
            n_fail++;
            $error("FAIL %s data_out t=%0t observed=%h expected=%h", tag, $time, data_out, exp_data);
        end
        n_checks++;
        assert (packet_end === exp_end) else begin
            n_fail++;
            $error("FAIL %s packet_end t=%0t observed=%b expected=%b", tag, $time, packet_end, exp_end);
        end
        $display("t=%0t %-8s rst=%b flit=%h -> data_out=%h packet_end=%b", $time, tag, rst, f,
                 data_out, packet_end);
        @(negedge clk);
    endtask

    initial begin
        logic [47:0] f;
        logic [47:0] a;
        logic [47:0] b;
        int          hold;
        n_checks = 0;
        n_fail   = 0;
        m_have   = 1'b0;
        m_last   = 48'h0;

        // Reset edge at 5ns with an undriven input, then an idle edge at 15ns.
        step('x, 1'b1, "reset");
        step(48'h0, 1'b0, "idle");

        // Tail flit applied at 20ns: words at edges 25 and 35.
        step(48'h1234_ABCD_FFFF, 1'b0, "flit1");
        step(48'h1234_ABCD_FFFF, 1'b0, "flit1");

        // New flit held for 1000ns: emitted once, then zeros.
        for (int i = 0; i < 100; i++) step(48'h3232_6767_FFFF, 1'b0, "hold");

        // Two-flit packet on consecutive acceptance points.
        step(48'hAAAA_BBBB_8000, 1'b0, "nontail");
        step(48'hCCCC_DDDD_C000, 1'b0, "tail");
        for (int i = 0; i < 3; i++) step(48'hCCCC_DDDD_C000, 1'b0, "tail");

        // VALID=0 flit is never taken.
        for (int i = 0; i < 4; i++) step(48'h1111_2222_7FFF, 1'b0, "invalid");

        // Reset mid-serialisation drops the flit; the same value is taken again afterwards.
        step(48'h1234_ABCD_FFFF, 1'b0, "midrst");
        step(48'h1234_ABCD_FFFF, 1'b1, "midrst");
        for (int i = 0; i < 3; i++) step(48'h1234_ABCD_FFFF, 1'b0, "midrst");

        // A -> B -> A: each change is accepted in turn.
        step(48'h5555_6666_8000, 1'b0, "aba");
        step(48'h5555_6666_8000, 1'b0, "aba");
        step(48'h7777_8888_8000, 1'b0, "aba");
        step(48'h7777_8888_8000, 1'b0, "aba");
        step(48'h5555_6666_C000, 1'b0, "aba");
        step(48'h5555_6666_8000, 1'b0, "aba");
        for (int i = 0; i < 3; i++) step(48'h5555_6666_8000, 1'b0, "aba");

        // Random flits: mixed VALID/TAIL, random hold lengths, revisits of older values, rare resets.
        a = 48'h0;
        b = 48'h0;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0:       f = a;
                1:       f = b;
                default: begin
                    f[47:16] = $urandom;
                    f[15:0]  = 16'($urandom);
                    f[15]    = ($urandom_range(0, 3) != 0);
                end
            endcase
            a    = b;
            b    = f;
            hold = $urandom_range(1, 3);
            for (int k = 0; k < hold; k++) begin
                step(f, ($urandom_range(0, 39) == 0), "random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
